// File: rtl/motion_pkg.sv
// Shared definitions for the step-rate sequencer: FSM states and the layout
// of a 32-bit motion segment word popped from the segment FIFO.
package motion_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FETCH    = 2'd1,
        ST_WAIT_VLD = 2'd2,
        ST_RUN      = 2'd3
    } seq_state_e;

    localparam int SEG_INC_LSB = 0;
    localparam int SEG_INC_W   = 16;
    localparam int SEG_DUR_LSB = 16;
    localparam int SEG_DUR_W   = 16;

    localparam logic [SEG_DUR_W-1:0] DUR_MIN = 16'd1;

    // Cycles left after the first RUN cycle; a zero duration runs like DUR_MIN.
    function automatic logic [SEG_DUR_W-1:0] seg_remain(input logic [SEG_DUR_W-1:0] dur);
        logic [SEG_DUR_W-1:0] res;
        if (dur < DUR_MIN) begin
            res = 16'd0;
        end else begin
            res = dur - DUR_MIN;
        end
        return res;
    endfunction

endpackage

// File: rtl/step_edge_counter.sv
// Counts rising edges of the pulse generator output, with a synchronous clear
// used when the sequencer starts a new run.
module step_edge_counter (
    input  logic        clock_250k,
    input  logic        reset,
    input  logic        pulse_in,
    input  logic        clear,
    output logic [31:0] count
);

    logic        pulse_d_r;
    logic [31:0] count_r;
    logic        rise_s;

    assign rise_s = pulse_in & ~pulse_d_r;
    assign count  = count_r;

    // Pulse history and wrapping edge counter.
    always_ff @(posedge clock_250k or posedge reset) begin
        if (reset) begin
            pulse_d_r <= 1'b0;
            count_r   <= 32'd0;
        end else begin
            pulse_d_r <= pulse_in;
            if (clear) begin
                count_r <= 32'd0;
            end else if (rise_s) begin
                count_r <= count_r + 32'd1;
            end else begin
                count_r <= count_r;
            end
        end
    end

endmodule

// File: rtl/step_rate_sequencer.sv
// Pops motion segments from a FIFO and drives the pulse generator increment
// for each segment's duration, chaining segments without a rate gap.
module step_rate_sequencer #(
    parameter int VLD_TIMEOUT = 4,
    parameter int INC_W       = 16
) (
    input  logic             clock_250k,
    input  logic             reset,
    input  logic             enable,
    input  logic             abort,
    input  logic             clear_err,
    input  logic [31:0]      fifo_dout,
    input  logic             fifo_empty,
    input  logic             fifo_vld,
    input  logic             pulse_in,
    output logic             fifo_rd,
    output logic [INC_W-1:0] rate_inc,
    output logic             busy,
    output logic             seg_done,
    output logic             underrun,
    output logic             vld_err,
    output logic [31:0]      step_count
);

    import motion_pkg::*;

    localparam int TMR_W = $clog2(VLD_TIMEOUT + 1);

    seq_state_e           state_r, state_nxt_s;
    logic                 fifo_rd_r, fifo_rd_nxt_s;
    logic [INC_W-1:0]     rate_inc_r, rate_inc_nxt_s;
    logic                 busy_r;
    logic                 seg_done_r, seg_done_nxt_s;
    logic                 underrun_r, underrun_set_s;
    logic                 vld_err_r, vld_err_set_s;
    logic [SEG_DUR_W-1:0] remain_r, remain_nxt_s;
    logic [TMR_W-1:0]     timer_r, timer_nxt_s;
    logic                 start_ok_r;
    logic                 cnt_clear_s;

    // Next-state and next-output decode; abort overrides everything else.
    always_comb begin
        state_nxt_s    = state_r;
        fifo_rd_nxt_s  = 1'b0;
        rate_inc_nxt_s = rate_inc_r;
        seg_done_nxt_s = 1'b0;
        remain_nxt_s   = remain_r;
        timer_nxt_s    = timer_r;
        underrun_set_s = 1'b0;
        vld_err_set_s  = 1'b0;
        cnt_clear_s    = 1'b0;
        if (abort) begin
            state_nxt_s    = ST_IDLE;
            rate_inc_nxt_s = {INC_W{1'b0}};
            remain_nxt_s   = {SEG_DUR_W{1'b0}};
            timer_nxt_s    = {TMR_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    rate_inc_nxt_s = {INC_W{1'b0}};
                    // start_ok_r keeps the first edge after reset release quiet
                    if (enable && !fifo_empty && start_ok_r) begin
                        state_nxt_s   = ST_FETCH;
                        fifo_rd_nxt_s = 1'b1;
                        cnt_clear_s   = 1'b1;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_FETCH: begin
                    state_nxt_s = ST_WAIT_VLD;
                    timer_nxt_s = TMR_W'(1);
                end
                ST_WAIT_VLD: begin
                    if (fifo_vld) begin
                        state_nxt_s    = ST_RUN;
                        rate_inc_nxt_s = INC_W'(fifo_dout[SEG_INC_LSB +: SEG_INC_W]);
                        remain_nxt_s   = seg_remain(fifo_dout[SEG_DUR_LSB +: SEG_DUR_W]);
                        timer_nxt_s    = {TMR_W{1'b0}};
                    end else if (timer_r >= TMR_W'(VLD_TIMEOUT)) begin
                        state_nxt_s    = ST_IDLE;
                        rate_inc_nxt_s = {INC_W{1'b0}};
                        vld_err_set_s  = 1'b1;
                        timer_nxt_s    = {TMR_W{1'b0}};
                    end else begin
                        timer_nxt_s = timer_r + TMR_W'(1);
                    end
                end
                ST_RUN: begin
                    if (remain_r != 16'd0) begin
                        remain_nxt_s = remain_r - 16'd1;
                    end else begin
                        seg_done_nxt_s = 1'b1;
                        if (enable && !fifo_empty) begin
                            // rate_inc holds through the refetch
                            state_nxt_s   = ST_FETCH;
                            fifo_rd_nxt_s = 1'b1;
                        end else if (enable) begin
                            state_nxt_s    = ST_IDLE;
                            rate_inc_nxt_s = {INC_W{1'b0}};
                            underrun_set_s = 1'b1;
                        end else begin
                            state_nxt_s    = ST_IDLE;
                            rate_inc_nxt_s = {INC_W{1'b0}};
                        end
                    end
                end
                default: begin
                    state_nxt_s    = ST_IDLE;
                    rate_inc_nxt_s = {INC_W{1'b0}};
                end
            endcase
        end
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clock_250k or posedge reset) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            fifo_rd_r  <= 1'b0;
            rate_inc_r <= {INC_W{1'b0}};
            busy_r     <= 1'b0;
            seg_done_r <= 1'b0;
            remain_r   <= {SEG_DUR_W{1'b0}};
            timer_r    <= {TMR_W{1'b0}};
            start_ok_r <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            fifo_rd_r  <= fifo_rd_nxt_s;
            rate_inc_r <= rate_inc_nxt_s;
            busy_r     <= (state_nxt_s != ST_IDLE);
            seg_done_r <= seg_done_nxt_s;
            remain_r   <= remain_nxt_s;
            timer_r    <= timer_nxt_s;
            start_ok_r <= 1'b1;
        end
    end

    // Sticky error flags; a set in the same cycle beats clear_err.
    always_ff @(posedge clock_250k or posedge reset) begin
        if (reset) begin
            underrun_r <= 1'b0;
            vld_err_r  <= 1'b0;
        end else begin
            if (underrun_set_s) begin
                underrun_r <= 1'b1;
            end else if (clear_err) begin
                underrun_r <= 1'b0;
            end else begin
                underrun_r <= underrun_r;
            end
            if (vld_err_set_s) begin
                vld_err_r <= 1'b1;
            end else if (clear_err) begin
                vld_err_r <= 1'b0;
            end else begin
                vld_err_r <= vld_err_r;
            end
        end
    end

    step_edge_counter u_edge_counter (
        .clock_250k (clock_250k),
        .reset      (reset),
        .pulse_in   (pulse_in),
        .clear      (cnt_clear_s),
        .count      (step_count)
    );

    assign fifo_rd  = fifo_rd_r;
    assign rate_inc = rate_inc_r;
    assign busy     = busy_r;
    assign seg_done = seg_done_r;
    assign underrun = underrun_r;
    assign vld_err  = vld_err_r;

endmodule

// File: tb/tb_step_rate_sequencer.sv
// Directed bench for step_rate_sequencer: a modelled segment FIFO with a
// scoreboard of words handed to the sequencer, checked as they take effect.
module tb_step_rate_sequencer;

    logic        clock_250k = 1'b0;
    logic        reset      = 1'b1;
    logic        enable     = 1'b0;
    logic        abort      = 1'b0;
    logic        clear_err  = 1'b0;
    logic [31:0] fifo_dout  = 32'h0;
    logic        fifo_empty = 1'b1;
    logic        fifo_vld   = 1'b0;
    logic        pulse_in   = 1'b0;
    logic        fifo_rd;
    logic [15:0] rate_inc;
    logic        busy;
    logic        seg_done;
    logic        underrun;
    logic        vld_err;
    logic [31:0] step_count;

    int          n_cmp    = 0;
    int          n_err    = 0;
    int          pending  = 0;
    logic [15:0] exp_rate = 16'h0;
    logic [31:0] exp_q[$];

    step_rate_sequencer #(.VLD_TIMEOUT(4), .INC_W(16)) dut (
        .clock_250k (clock_250k),
        .reset      (reset),
        .enable     (enable),
        .abort      (abort),
        .clear_err  (clear_err),
        .fifo_dout  (fifo_dout),
        .fifo_empty (fifo_empty),
        .fifo_vld   (fifo_vld),
        .pulse_in   (pulse_in),
        .fifo_rd    (fifo_rd),
        .rate_inc   (rate_inc),
        .busy       (busy),
        .seg_done   (seg_done),
        .underrun   (underrun),
        .vld_err    (vld_err),
        .step_count (step_count)
    );

    always #5 clock_250k = ~clock_250k;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clock_250k);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_pending(input int n);
        pending    = n;
        fifo_empty = (n == 0);
    endtask

    // Wait for the pop, answer after 'delay' cycles, then follow the segment to seg_done.
    task automatic serve(input logic [31:0] word, input int delay);
        int          n;
        int          run;
        int          dur_eff;
        logic [31:0] exp_w;
        n = 0;
        while (fifo_rd !== 1'b1 && n < 20) begin
            check("rate_before_fetch", rate_inc, exp_rate);
            tick();
            n++;
        end
        check("fifo_rd_seen", fifo_rd, 32'd1);
        set_pending(pending - 1);
        for (int i = 0; i < delay; i++) begin
            tick();
            check("rate_fetch_gap", rate_inc, exp_rate);
            check("fifo_rd_single", fifo_rd, 32'd0);
        end
        fifo_vld  = 1'b1;
        fifo_dout = word;
        exp_q.push_back(word);
        tick();
        fifo_vld  = 1'b0;
        fifo_dout = 32'h0;
        exp_w     = exp_q.pop_front();
        check("rate_load", rate_inc, exp_w[15:0]);
        exp_rate = exp_w[15:0];
        dur_eff  = (exp_w[31:16] == 16'd0) ? 1 : int'(exp_w[31:16]);
        run = 0;
        while (seg_done !== 1'b1 && run < 40) begin
            check("rate_run", rate_inc, exp_rate);
            check("busy_run", busy, 32'd1);
            run++;
            tick();
        end
        check("run_len", run, dur_eff);
    endtask

    initial begin
        int          n;
        logic        prev;
        logic [31:0] exp_steps;

        // reset values, with a word already waiting
        enable = 1'b1;
        set_pending(1);
        tick();
        tick();
        check("rst_fifo_rd", fifo_rd, 32'd0);
        check("rst_rate", rate_inc, 32'd0);
        check("rst_busy", busy, 32'd0);
        check("rst_seg_done", seg_done, 32'd0);
        check("rst_underrun", underrun, 32'd0);
        check("rst_vld_err", vld_err, 32'd0);
        check("rst_steps", step_count, 32'd0);
        reset = 1'b0;
        tick();
        check("no_rd_first_edge", fifo_rd, 32'd0);

        // single word, FIFO then empty
        serve({16'd3, 16'h0100}, 1);
        check("s1_rate_zero", rate_inc, 32'd0);
        check("s1_underrun", underrun, 32'd1);
        check("s1_idle", busy, 32'd0);
        exp_rate = 16'h0;
        tick();
        check("s1_seg_done_pulse", seg_done, 32'd0);
        check("s1_no_rd", fifo_rd, 32'd0);

        // two words back-to-back; clear_err held across the last segment end
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        check("clr_underrun", underrun, 32'd0);
        set_pending(2);
        serve({16'd2, 16'h0200}, 1);
        check("b2b_first_underrun", underrun, 32'd0);
        check("b2b_rate_held", rate_inc, 32'h0200);
        clear_err = 1'b1;
        serve({16'd4, 16'h0400}, 2);
        clear_err = 1'b0;
        check("b2b_set_beats_clear", underrun, 32'd1);
        check("b2b_rate_zero", rate_inc, 32'd0);
        exp_rate = 16'h0;
        tick();
        check("b2b_underrun_sticky", underrun, 32'd1);

        // longest accepted fifo_vld delay
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        set_pending(1);
        serve({16'd1, 16'h0010}, 4);
        check("d4_underrun", underrun, 32'd1);
        check("d4_vld_err", vld_err, 32'd0);
        exp_rate = 16'h0;
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;

        // fifo_vld withheld past the timeout
        set_pending(1);
        n = 0;
        while (fifo_rd !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("to_fifo_rd", fifo_rd, 32'd1);
        set_pending(0);
        repeat (5) tick();
        check("to_busy", busy, 32'd0);
        check("to_vld_err", vld_err, 32'd1);
        check("to_rate", rate_inc, 32'd0);
        fifo_vld  = 1'b1;
        fifo_dout = {16'd2, 16'h0777};
        tick();
        fifo_vld  = 1'b0;
        fifo_dout = 32'h0;
        check("late_vld_rate", rate_inc, 32'd0);
        check("late_vld_busy", busy, 32'd0);
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        check("to_clear", vld_err, 32'd0);

        // abort together with fifo_vld
        set_pending(1);
        n = 0;
        while (fifo_rd !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("ab_fifo_rd", fifo_rd, 32'd1);
        set_pending(0);
        tick();
        fifo_vld  = 1'b1;
        fifo_dout = {16'd3, 16'h0555};
        abort     = 1'b1;
        tick();
        fifo_vld  = 1'b0;
        abort     = 1'b0;
        fifo_dout = 32'h0;
        check("ab_busy", busy, 32'd0);
        check("ab_rate", rate_inc, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("ab_no_seg_done", seg_done, 32'd0);
            check("ab_rate_after", rate_inc, 32'd0);
        end

        // zero duration runs one cycle
        set_pending(1);
        serve({16'd0, 16'h8000}, 1);
        check("d0_rate_zero", rate_inc, 32'd0);
        exp_rate = 16'h0;
        tick();
        check("d0_steps_start", step_count, 32'd0);

        // pulse edges counted
        prev      = 1'b0;
        exp_steps = 32'd0;
        for (int i = 0; i < 10; i++) begin
            pulse_in = (i % 2 == 0);
            if (pulse_in && !prev) begin
                exp_steps = exp_steps + 32'd1;
            end
            prev = pulse_in;
            tick();
        end
        pulse_in = 1'b0;
        tick();
        check("steps_toggle", step_count, exp_steps);

        // counter wraps from all-ones
        force dut.u_edge_counter.count_r = 32'hFFFF_FFFF;
        #1;
        release dut.u_edge_counter.count_r;
        exp_steps = 32'hFFFF_FFFF;
        exp_steps = exp_steps + 32'd1;
        pulse_in  = 1'b1;
        tick();
        pulse_in  = 1'b0;
        tick();
        check("steps_wrap", step_count, exp_steps);

        // asynchronous reset in the middle of a segment
        set_pending(1);
        n = 0;
        while (fifo_rd !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        set_pending(0);
        tick();
        fifo_vld  = 1'b1;
        fifo_dout = {16'd5, 16'h0300};
        tick();
        fifo_vld  = 1'b0;
        fifo_dout = 32'h0;
        check("mid_rate", rate_inc, 32'h0300);
        #2;
        reset = 1'b1;
        #1;
        check("async_rate", rate_inc, 32'd0);
        check("async_busy", busy, 32'd0);
        check("async_steps", step_count, 32'd0);
        tick();
        reset = 1'b0;
        set_pending(1);
        tick();
        check("rel_no_rd", fifo_rd, 32'd0);
        tick();
        check("rel_rd", fifo_rd, 32'd1);
        enable = 1'b0;
        abort  = 1'b1;
        tick();
        abort  = 1'b0;
        check("rel_abort_idle", busy, 32'd0);

        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
